// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - page-copy DMA arbiter sharing the 6502 memory bus
// Optional completion pulse on dma_done when DMA_DONE_IRQ_EN is defined.
module dma_bus_arbiter #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [15:0] DMA_DST_ADDR = 16'h2004,
   parameter int          PARITY_ALIGN = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   input  logic        cpu_rw,
   input  logic [7:0]  mem_rdata,
   output logic        ready,
   output logic [15:0] addr,
   output logic [7:0]  o_data,
   output logic        RW,
   output logic        dma_active,
   output logic        dma_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_page;
   logic [7:0]  r_idx;
   logic [7:0]  r_rbuf;
   logic        r_cyc_odd;
   logic        w_trigger;
   logic        w_last_write;

   assign w_trigger    = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);
   assign w_last_write = (r_state == S_WRITE) && (r_idx == 8'hFF);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_page    <= 8'h00;
         r_idx     <= 8'h00;
         r_rbuf    <= 8'h00;
         r_cyc_odd <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_cyc_odd <= ~r_cyc_odd;
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_page <= cpu_data;
                  r_idx  <= 8'h00;
               end
            end
            S_READ:  r_rbuf <= mem_rdata;
            S_WRITE: r_idx  <= r_idx + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_trigger) w_next = S_HALT;
         // The core only freezes on a read, so stay in HALT while it keeps writing.
         S_HALT: begin
            if (cpu_rw) begin
               if ((PARITY_ALIGN != 0) && !r_cyc_odd) w_next = S_ALIGN;
               else                                   w_next = S_READ;
            end
         end
         S_ALIGN: w_next = S_READ;
         S_READ:  w_next = S_WRITE;
         S_WRITE: w_next = (r_idx == 8'hFF) ? S_IDLE : S_READ;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      addr   = cpu_addr;
      o_data = cpu_data;
      RW     = cpu_rw;
      case (r_state)
         S_READ: begin
            addr   = {r_page, r_idx};
            o_data = 8'h00;
            RW     = 1'b1;
         end
         S_WRITE: begin
            addr   = DMA_DST_ADDR;
            o_data = r_rbuf;
            RW     = 1'b0;
         end
         default: ;
      endcase
   end

   assign ready      = (r_state == S_IDLE);
   assign dma_active = ~ready;

`ifdef DMA_DONE_IRQ_EN
   logic r_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_done <= 1'b0;
      else       r_done <= w_last_write;
   end

   assign dma_done = r_done;
`else
   logic w_unused;

   assign w_unused = w_last_write;
   assign dma_done = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [15:0] cpu_addr = 16'h1234;
   logic [7:0]  cpu_data = 8'h00;
   logic        cpu_rw = 1'b1;
   logic [7:0]  mem_rdata;
   logic        ready;
   logic [15:0] addr;
   logic [7:0]  o_data;
   logic        RW;
   logic        dma_active;
   logic        dma_done;

   int checks = 0;
   int errors = 0;

`ifdef DMA_DONE_IRQ_EN
   localparam int EXP_DONE = 1;
`else
   localparam int EXP_DONE = 0;
`endif

   dma_bus_arbiter dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_rw     (cpu_rw),
      .mem_rdata  (mem_rdata),
      .ready      (ready),
      .addr       (addr),
      .o_data     (o_data),
      .RW         (RW),
      .dma_active (dma_active),
      .dma_done   (dma_done)
   );

   always #5 i_clk = ~i_clk;

   logic [7:0] mem [0:65535];
   assign mem_rdata = mem[addr];

   int          cyc;
   logic [7:0]  wq [$];
   logic [15:0] rq [$];
   int          par_err = 0;
   int          done_cnt = 0;

   always @(posedge i_clk) begin
      if (i_rst) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(posedge i_clk) begin
      if (!i_rst && dma_active) begin
         if (!RW && addr == 16'h2004) wq.push_back(o_data);
         if (RW && addr[15:12] == 4'h0) begin
            rq.push_back(addr);
            if (cyc[0]) par_err = par_err + 1;
         end
      end
      if (!i_rst && dma_done) done_cnt = done_cnt + 1;
   end

   function automatic int first_bad_w(input int w0, input logic [7:0] key);
      for (int i = 0; i < 256; i++) begin
         if (w0 + i >= wq.size()) return i;
         if (wq[w0 + i] !== (i[7:0] ^ key)) return i;
      end
      return -1;
   endfunction

   function automatic int first_bad_r(input int r0, input logic [7:0] pg);
      for (int i = 0; i < 256; i++) begin
         if (r0 + i >= rq.size()) return i;
         if (rq[r0 + i] !== {pg, i[7:0]}) return i;
      end
      return -1;
   endfunction

   task automatic wait_parity(input int par);
      @(negedge i_clk);
      if (cyc[0] != par[0]) @(negedge i_clk);
   endtask

   task automatic trigger(input logic [7:0] pg, input int par);
      wait_parity(par);
      cpu_rw   = 1'b0;
      cpu_addr = 16'h4014;
      cpu_data = pg;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge i_clk);
      cpu_rw   = 1'b0;
      cpu_addr = a;
      cpu_data = d;
   endtask

   task automatic stall_read(output int stall, output logic done_seen);
      stall = 0;
      @(negedge i_clk);
      cpu_rw   = 1'b1;
      cpu_addr = 16'h8000;
      cpu_data = 8'h00;
      #1;
      while (ready !== 1'b1 && stall < 3000) begin
         stall++;
         @(negedge i_clk);
         #1;
      end
      done_seen = dma_done;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge i_clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      checks++;
      if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", dma_active); end
      checks++;
      if (dma_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dma_done); end
      i_rst = 1'b0;
      @(negedge i_clk);
      #1;
      checks++;
      if (addr !== 16'h1234 || RW !== 1'b1) begin
         errors++; $display("FAIL idle_pass addr %h rw %b want 1234 1", addr, RW);
      end
      checks++;
      if (ready !== 1'b1 || dma_active !== 1'b0) begin
         errors++; $display("FAIL idle_ready ready %b active %b want 1 0", ready, dma_active);
      end
   endtask

   task automatic check_copy(input string nm, input int w0, input int r0, input int p0,
                             input logic [7:0] pg, input logic [7:0] key);
      int b;
      checks++;
      if (wq.size() - w0 != 256) begin
         errors++; $display("FAIL %s_nwrites got %0d want 256", nm, wq.size() - w0);
      end
      b = first_bad_w(w0, key);
      checks++;
      if (b != -1) begin errors++; $display("FAIL %s_wdata first bad index %0d want none", nm, b); end
      b = first_bad_r(r0, pg);
      checks++;
      if (b != -1) begin errors++; $display("FAIL %s_raddr first bad index %0d want none", nm, b); end
      checks++;
      if (par_err - p0 != 0) begin
         errors++; $display("FAIL %s_parity odd reads %0d want 0", nm, par_err - p0);
      end
   endtask

   task automatic check_done(input string nm, input logic done_seen, input int d0);
      checks++;
      if (done_seen !== EXP_DONE[0]) begin
         errors++; $display("FAIL %s_done_at_ready got %b want %0d", nm, done_seen, EXP_DONE);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (done_cnt - d0 != EXP_DONE) begin
         errors++; $display("FAIL %s_done_count got %0d want %0d", nm, done_cnt - d0, EXP_DONE);
      end
   endtask

   task automatic test_trigger_even;
      int w0, r0, p0, d0, st;
      logic ds;
      w0 = wq.size(); r0 = rq.size(); p0 = par_err; d0 = done_cnt;
      trigger(8'h02, 0);
      #1;
      checks++;
      if (addr !== 16'h4014 || RW !== 1'b0 || o_data !== 8'h02 || ready !== 1'b1) begin
         errors++;
         $display("FAIL trig_pass addr %h rw %b data %h ready %b want 4014 0 02 1", addr, RW, o_data, ready);
      end
      stall_read(st, ds);
      checks++;
      if (st != 513) begin errors++; $display("FAIL even_stall got %0d want 513", st); end
      check_copy("even", w0, r0, p0, 8'h02, 8'h5A);
      check_done("even", ds, d0);
   endtask

   task automatic test_parity;
      int w0, r0, p0, d0, st;
      logic ds;
      w0 = wq.size(); r0 = rq.size(); p0 = par_err; d0 = done_cnt;
      trigger(8'h02, 1);
      stall_read(st, ds);
      checks++;
      if (st != 514) begin errors++; $display("FAIL odd_stall got %0d want 514", st); end
      check_copy("odd", w0, r0, p0, 8'h02, 8'h5A);
      check_done("odd", ds, d0);
   endtask

   task automatic test_halt_writes;
      int w0, r0, p0, d0, st;
      logic ds;
      w0 = wq.size(); r0 = rq.size(); p0 = par_err; d0 = done_cnt;
      trigger(8'h03, 0);
      cpu_wr(16'h0100, 8'h11);
      #1;
      checks++;
      if (addr !== 16'h0100 || o_data !== 8'h11 || RW !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL halt_wr0 addr %h data %h rw %b ready %b want 0100 11 0 0", addr, o_data, RW, ready);
      end
      cpu_wr(16'h0101, 8'h22);
      #1;
      checks++;
      if (addr !== 16'h0101 || o_data !== 8'h22 || RW !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL halt_wr1 addr %h data %h rw %b ready %b want 0101 22 0 0", addr, o_data, RW, ready);
      end
      cpu_wr(16'h4014, 8'h07);
      #1;
      checks++;
      if (addr !== 16'h4014 || o_data !== 8'h07 || ready !== 1'b0) begin
         errors++; $display("FAIL halt_retrig addr %h data %h ready %b want 4014 07 0", addr, o_data, ready);
      end
      stall_read(st, ds);
      checks++;
      if (st + 3 != 517) begin errors++; $display("FAIL halt_stall got %0d want 517", st + 3); end
      check_copy("halt", w0, r0, p0, 8'h03, 8'hA5);
      check_done("halt", ds, d0);
   endtask

   task automatic test_reset_mid;
      int w0, r0, p0, d0, st, n;
      logic ds;
      logic hit;
      w0 = wq.size(); d0 = done_cnt;
      trigger(8'h02, 0);
      @(negedge i_clk);
      cpu_rw   = 1'b1;
      cpu_addr = 16'h8000;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 400) begin
         #1;
         if (addr == 16'h2004 && RW == 1'b0 && wq.size() - w0 == 64) hit = 1'b1;
         else begin
            n++;
            @(negedge i_clk);
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL abort_reach idx40 not seen after %0d cycles want seen", n); end
      i_rst = 1'b1;
      @(negedge i_clk);
      #1;
      checks++;
      if (ready !== 1'b1 || RW !== cpu_rw || dma_active !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle ready %b rw %b active %b want 1 %b 0", ready, RW, dma_active, cpu_rw);
      end
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
      w0 = wq.size(); r0 = rq.size(); p0 = par_err; d0 = done_cnt;
      trigger(8'h04, 0);
      stall_read(st, ds);
      checks++;
      if (st != 513) begin errors++; $display("FAIL restart_stall got %0d want 513", st); end
      check_copy("restart", w0, r0, p0, 8'h04, 8'h3C);
      check_done("restart", ds, d0);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'hEE;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = i[7:0] ^ 8'h5A;
         mem[16'h0300 + i] = i[7:0] ^ 8'hA5;
         mem[16'h0400 + i] = i[7:0] ^ 8'h3C;
      end
      test_reset;
      test_trigger_even;
      test_parity;
      test_halt_writes;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
